// File: rtl/par2serial_pkg.sv
// Shared constants and FSM encoding for the 4-lane parallel-to-serial block.
package par2serial_pkg;

    localparam int unsigned BIT_CNT_W    = 3;
    localparam int unsigned NUM_LANES    = 4;
    localparam logic [7:0]  COM_SYM_DEF  = 8'hBC;
    localparam logic [7:0]  IDLE_SYM_DEF = 8'h7C;

    typedef enum logic {
        ST_TRAIN  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/lane_serializer.sv
// One lane: one-entry holding register with ready handshake feeding an
// MSB-first 8-bit shift register.
module lane_serializer
    import par2serial_pkg::*;
#(
    parameter logic [7:0] COM_SYM  = COM_SYM_DEF,
    parameter logic [7:0] IDLE_SYM = IDLE_SYM_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       active_i,
    input  logic       train_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       serial_o
);

    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_v_q, hold_v_d;
    logic [7:0] shreg_q, shreg_d;
    logic       accept;

    // A full hold register can still take a byte on the load edge, since
    // its current content moves into the shift register on that same edge.
    assign ready_o  = active_i && (!hold_v_q || load_i);
    assign accept   = valid_i && ready_o;
    assign serial_o = shreg_q[7];

    always_comb begin
        hold_data_d = hold_data_q;
        hold_v_d    = hold_v_q;
        shreg_d     = {shreg_q[6:0], 1'b0};
        if (load_i) begin
            if (train_i) begin
                shreg_d = COM_SYM;
            end else begin
                shreg_d = hold_v_q ? hold_data_q : IDLE_SYM;
            end
            hold_v_d = 1'b0;
        end
        if (accept) begin
            hold_data_d = data_i;
            hold_v_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_data_q <= '0;
            hold_v_q    <= 1'b0;
            shreg_q     <= '0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_v_q    <= hold_v_d;
            shreg_q     <= shreg_d;
        end
    end

endmodule

// File: rtl/par2serial_4lane.sv
// Four-lane serializer: shared bit counter and TRAIN/ACTIVE sequencing,
// with per-lane holding and shifting in lane_serializer.
module par2serial_4lane
    import par2serial_pkg::*;
#(
    parameter int unsigned TRAIN_SYMS = 4,
    parameter logic [7:0]  COM_SYM    = COM_SYM_DEF,
    parameter logic [7:0]  IDLE_SYM   = IDLE_SYM_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic       valid_in0,
    input  logic       valid_in1,
    input  logic       valid_in2,
    input  logic       valid_in3,
    output logic       ready_out0,
    output logic       ready_out1,
    output logic       ready_out2,
    output logic       ready_out3,
    output logic       data_out0,
    output logic       data_out1,
    output logic       data_out2,
    output logic       data_out3,
    output logic       active_out
);

    localparam logic [7:0] LAST_TRAIN = 8'(TRAIN_SYMS - 1);

    state_t                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]             train_cnt_q, train_cnt_d;
    logic                   load;
    logic                   lane_active;
    logic                   lane_train;

    logic [7:0]             lane_data [NUM_LANES];
    logic [NUM_LANES-1:0]   lane_valid;
    logic [NUM_LANES-1:0]   lane_ready;
    logic [NUM_LANES-1:0]   lane_serial;

    assign load        = (bit_cnt_q == '1);
    assign active_out  = (state_q == ST_ACTIVE);
    // Reset gates ready combinationally so no byte is offered a handshake
    // in a cycle whose edge is going to clear everything.
    assign lane_active = (state_q == ST_ACTIVE) && !reset;
    assign lane_train  = (state_q == ST_TRAIN);

    always_comb begin
        bit_cnt_d   = bit_cnt_q + 1'b1;
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        if (state_q == ST_TRAIN && load) begin
            train_cnt_d = train_cnt_q + 8'd1;
            if (train_cnt_q == LAST_TRAIN) begin
                state_d = ST_ACTIVE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_TRAIN;
            bit_cnt_q   <= '0;
            train_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            train_cnt_q <= train_cnt_d;
        end
    end

    assign lane_data[0] = in0;
    assign lane_data[1] = in1;
    assign lane_data[2] = in2;
    assign lane_data[3] = in3;
    assign lane_valid   = {valid_in3, valid_in2, valid_in1, valid_in0};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_serializer #(
            .COM_SYM  (COM_SYM),
            .IDLE_SYM (IDLE_SYM)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .load_i   (load),
            .active_i (lane_active),
            .train_i  (lane_train),
            .data_i   (lane_data[g]),
            .valid_i  (lane_valid[g]),
            .ready_o  (lane_ready[g]),
            .serial_o (lane_serial[g])
        );
    end

    assign {ready_out3, ready_out2, ready_out1, ready_out0} = lane_ready;
    assign {data_out3, data_out2, data_out1, data_out0}     = lane_serial;

endmodule
